hwpe_stream_realign_sequencer: RTL

Controller that sequences a misaligned 2D load for the stream realigner. From a byte base address, a line length in words, a line count and a line stride, it issues word-aligned TCDM load requests. For each request it drives the realigner's control fields: enable, realign, first, last, last_packet, strb_valid, line_length and byte strobe. It sits between the job/register file and the TCDM load port, alongside the realigner instance.

---
 rtl/hwpe_stream_realign_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/hwpe_stream_realign_sequencer.sv
// hwpe_stream_realign_sequencer: issues word-aligned TCDM loads for a misaligned 2D job
// and drives the stream realigner's per-word control fields.
module hwpe_stream_realign_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0]    line_length_i,
    input  logic [LEN_WIDTH-1:0]    nb_lines_i,
    input  logic [ADDR_WIDTH-1:0]   stride_i,
    output logic                    req_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    input  logic                    gnt_i,
    output logic                    ctrl_enable_o,
    output logic                    ctrl_realign_o,
    output logic                    ctrl_first_o,
    output logic                    ctrl_last_o,
    output logic                    ctrl_last_packet_o,
    output logic                    ctrl_strb_valid_o,
    output logic [LEN_WIDTH-1:0]    ctrl_line_length_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    busy_o,
    output logic                    done_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);
    localparam logic [NB-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_line_base, r_stride;
    logic [LEN_WIDTH:0]    r_word_cnt, r_wpl;
    logic [LEN_WIDTH-1:0]  r_line_cnt, r_nb_lines, r_line_length;
    logic [OW-1:0]         r_off;
    logic                  r_realign;

    logic                  w_accept, w_zero, w_hs, w_last, w_last_pkt, w_realign;
    logic [NB-1:0]         w_lo;
    logic [ADDR_WIDTH-1:0] w_next_line;

    assign w_accept    = !clear_i && r_state != ISSUE && start_i;
    assign w_zero      = line_length_i == '0 || nb_lines_i == '0;
    assign w_realign   = |base_addr_i[OW-1:0];
    assign w_hs        = req_o && gnt_i && !clear_i;
    assign w_last      = r_word_cnt == r_wpl - (LEN_WIDTH+1)'(1);
    assign w_last_pkt  = w_last && r_line_cnt == r_nb_lines - LEN_WIDTH'(1);
    assign w_next_line = r_line_base + r_stride;
    assign w_lo        = ONES << r_off;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = clear_i ? IDLE :
                 w_accept ? (w_zero ? DONE : ISSUE) :
                 (w_hs && w_last_pkt) ? DONE : r_state;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr        <= '0;
            r_line_base   <= '0;
            r_stride      <= '0;
            r_word_cnt    <= '0;
            r_wpl         <= '0;
            r_line_cnt    <= '0;
            r_nb_lines    <= '0;
            r_line_length <= '0;
            r_off         <= '0;
            r_realign     <= 1'b0;
        end else if (w_accept) begin
            r_addr        <= {base_addr_i[ADDR_WIDTH-1:OW], OW'(0)};
            r_line_base   <= {base_addr_i[ADDR_WIDTH-1:OW], OW'(0)};
            r_stride      <= {stride_i[ADDR_WIDTH-1:OW], OW'(0)};
            r_word_cnt    <= '0;
            r_wpl         <= {1'b0, line_length_i} + (LEN_WIDTH+1)'(w_realign);
            r_line_cnt    <= '0;
            r_nb_lines    <= nb_lines_i;
            r_line_length <= line_length_i;
            r_off         <= base_addr_i[OW-1:0];
            r_realign     <= w_realign;
        end else if (w_hs) begin
            if (w_last) begin
                r_word_cnt  <= '0;
                r_line_cnt  <= r_line_cnt + LEN_WIDTH'(1);
                r_line_base <= w_next_line;
                r_addr      <= w_next_line;
            end else begin
                r_word_cnt  <= r_word_cnt + (LEN_WIDTH+1)'(1);
                r_addr      <= r_addr + ADDR_WIDTH'(NB);
            end
        end
    end

    assign req_o              = r_state == ISSUE;
    assign busy_o             = req_o;
    assign done_o             = r_state == DONE;
    assign addr_o             = r_addr;
    assign ctrl_enable_o      = r_state != IDLE;
    assign ctrl_realign_o     = ctrl_enable_o && r_realign;
    assign ctrl_first_o       = req_o && r_word_cnt == '0;
    assign ctrl_last_o        = req_o && w_last;
    assign ctrl_last_packet_o = req_o && w_last_pkt;
    assign ctrl_strb_valid_o  = req_o && gnt_i;
    assign ctrl_line_length_o = r_line_length;
    // first/last words of a misaligned line only carry the bytes on their side of the offset
    assign strb_o = !req_o ? '0 :
                    !r_realign ? ONES :
                    ctrl_first_o ? w_lo :
                    w_last ? ~w_lo : ONES;
endmodule
